ahb_slave_mem: RTL and testbench



---
 rtl/ahb_pkg.sv | 29 ++
 rtl/ahb_byte_ram.sv | 24 ++
 rtl/ahb_slave_mem.sv | 151 +++++++++++++++
 tb/tb_ahb_slave_mem.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder state encoding.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // NONSEQ and SEQ carry a transfer; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] t);
    case (t)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_byte_ram.sv
// Byte-wide memory: synchronous write, asynchronous read, contents never reset.
module ahb_byte_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  // Commit one byte per enabled clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a byte-wide memory, with programmable wait
// states and a two-cycle ERROR response outside its decode window.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          AW          = 8,
  parameter int          WAIT_STATES = 0
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata
);

  localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

  state_t        state;
  state_t        nxt_open;
  logic [2:0]    wcnt;
  logic          hreadyout_q;
  logic [1:0]    hresp_q;
  logic [31:0]   hrdata_q;

  logic [AW-1:0] addr_p0;
  logic          write_p0;
  logic          vld_p0;

  logic          addr_slot;
  logic          in_window;
  logic          accept;
  logic          rd_now;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic          unused_ok;

  // Only the low byte of the write bus is stored.
  assign unused_ok = ^Hwdata[31:8];

  // A new address phase may complete only in states that drive Hreadyout high;
  // this keeps the pending transfer intact even if Hreadyin misbehaves mid-wait.
  assign addr_slot = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign in_window = (Haddr[31:AW] == BASE_ADDR[31:AW]);
  assign accept    = addr_slot && Hreadyin && htrans_active(Htrans);

  function automatic state_t dest_state(input logic acc, input logic inwin);
    if (!acc)   return ST_IDLE;
    if (!inwin) return ST_ERR1;
    return (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
  endfunction

  function automatic logic ready_of(input state_t s);
    return !((s == ST_WAIT) || (s == ST_ERR1));
  endfunction

  function automatic logic [1:0] resp_of(input state_t s);
    return ((s == ST_ERR1) || (s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  endfunction

  assign nxt_open = dest_state(accept, in_window);

  // ---- address phase -> p0: capture the transfer attributes ----
  // Capture on an accepted transfer; an IDLE/BUSY slot clears the valid flag.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      addr_p0  <= '0;
      write_p0 <= 1'b0;
      vld_p0   <= 1'b0;
    end else if (addr_slot && Hreadyin) begin
      if (htrans_active(Htrans)) begin
        addr_p0  <= Haddr[AW-1:0];
        write_p0 <= Hwrite;
        vld_p0   <= 1'b1;
      end else begin
        vld_p0   <= 1'b0;
      end
    end
  end

  // Response FSM; Hreadyout/Hresp are registered from the next state.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          state       <= nxt_open;
          wcnt        <= (nxt_open == ST_WAIT) ? WS_LOAD : 3'd0;
          hreadyout_q <= ready_of(nxt_open);
          hresp_q     <= resp_of(nxt_open);
        end
        ST_WAIT: begin
          wcnt <= wcnt - 3'd1;
          if (wcnt == 3'd1) begin
            state       <= ST_DATA;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state       <= ST_IDLE;
          wcnt        <= '0;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // ---- p0 -> data phase: memory access in the DATA cycle ----
  // A reset landing on the DATA cycle abandons the write.
  assign ram_we = (state == ST_DATA) && vld_p0 && write_p0 && !Hreset;
  assign rd_now = (state == ST_DATA) && vld_p0 && !write_p0;

  ahb_byte_ram #(.AW(AW)) u_ram (
    .clk   (Hclk),
    .we    (ram_we),
    .waddr (addr_p0),
    .wdata (Hwdata[7:0]),
    .raddr (addr_p0),
    .rdata (ram_rdata)
  );

  // Remember the last returned byte so Hrdata holds between reads.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      hrdata_q <= '0;
    end else if (rd_now) begin
      hrdata_q <= {24'h0, ram_rdata};
    end
  end

  assign Hrdata    = rd_now ? {24'h0, ram_rdata} : hrdata_q;
  assign Hreadyout = hreadyout_q;
  assign Hresp     = hresp_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (0 and 2 wait states) driven by a
// pipelined master and checked against a transfer-level reference model.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    logic [1:0]  tr;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
  } xfer_t;

  logic Hclk = 1'b0;
  logic Hreset;
  always #5 Hclk = ~Hclk;

  logic        hwrite0, hreadyin0, hreadyout0;
  logic [1:0]  htrans0, hresp0;
  logic [31:0] haddr0, hwdata0, hrdata0;
  logic        hwrite1, hreadyin1, hreadyout1;
  logic [1:0]  htrans1, hresp1;
  logic [31:0] haddr1, hwdata1, hrdata1;

  ahb_slave_mem #(.BASE_ADDR(BASE), .AW(8), .WAIT_STATES(0)) dut0 (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(hwrite0), .Hreadyin(hreadyin0),
    .Htrans(htrans0), .Haddr(haddr0), .Hwdata(hwdata0),
    .Hreadyout(hreadyout0), .Hresp(hresp0), .Hrdata(hrdata0));

  ahb_slave_mem #(.BASE_ADDR(BASE), .AW(8), .WAIT_STATES(2)) dut1 (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(hwrite1), .Hreadyin(hreadyin1),
    .Htrans(htrans1), .Haddr(haddr1), .Hwdata(hwdata1),
    .Hreadyout(hreadyout1), .Hresp(hresp1), .Hrdata(hrdata1));

  int          tests = 0;
  int          fails = 0;
  int          ws_of [2] = '{0, 2};
  logic [7:0]  ref_mem [2][256];
  logic [31:0] last_rd [2];
  xfer_t       q[$];

  function automatic logic inwin(input logic [31:0] a);
    return a[31:8] == BASE[31:8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic put(input int d, input logic [1:0] tr, input logic [31:0] a,
                     input logic wr, input logic [31:0] wd, input logic ri);
    if (d == 0) begin
      htrans0 = tr; haddr0 = a; hwrite0 = wr; hwdata0 = wd; hreadyin0 = ri;
    end else begin
      htrans1 = tr; haddr1 = a; hwrite1 = wr; hwdata1 = wd; hreadyin1 = ri;
    end
  endtask

  task automatic get(input int d, output logic rdy, output logic [1:0] resp, output logic [31:0] rd);
    if (d == 0) begin
      rdy = hreadyout0; resp = hresp0; rd = hrdata0;
    end else begin
      rdy = hreadyout1; resp = hresp1; rd = hrdata1;
    end
  endtask

  task automatic push(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic [7:0] d);
    xfer_t x;
    x.tr = tr; x.a = a; x.wr = wr; x.d = d;
    q.push_back(x);
  endtask

  // Master + reference: every data phase is checked cycle by cycle against the
  // AHB rules (wait count, error pair, read byte, Hrdata hold).
  task automatic run(input int d, input int stall_pct);
    int          cur = 0;
    int          dp = -1;
    int          wcnt = 0;
    int          n = q.size();
    logic        rdy, ri, exp_rdy, xw;
    logic [1:0]  resp, exp_resp, xt;
    logic [31:0] rd, exp_rd, xa, r;
    while (cur < n || dp >= 0) begin
      @(negedge Hclk);
      get(d, rdy, resp, rd);
      if (dp < 0) begin
        exp_rdy = 1'b1; exp_resp = HRESP_OKAY;
      end else if (inwin(q[dp].a)) begin
        exp_rdy = (wcnt >= ws_of[d]); exp_resp = HRESP_OKAY;
      end else begin
        exp_rdy = (wcnt >= 1); exp_resp = HRESP_ERROR;
      end
      exp_rd = last_rd[d];
      if (dp >= 0 && exp_rdy && inwin(q[dp].a) && !q[dp].wr)
        exp_rd = {24'h0, ref_mem[d][q[dp].a[7:0]]};
      chk($sformatf("d%0d hreadyout", d), {31'h0, rdy}, {31'h0, exp_rdy});
      chk($sformatf("d%0d hresp", d), {30'h0, resp}, {30'h0, exp_resp});
      chk($sformatf("d%0d hrdata", d), rd, exp_rd);
      last_rd[d] = exp_rd;
      if (dp >= 0 && wcnt > 12) begin
        chk($sformatf("d%0d hang_bound", d), 32'(wcnt), 32'd0);
        q.delete();
        return;
      end
      ri = rdy;
      if (dp < 0 && $urandom_range(99) < stall_pct) ri = 1'b0;
      r = $urandom();
      xt = (cur < n) ? q[cur].tr : HTRANS_IDLE;
      xa = (cur < n) ? q[cur].a : r;
      xw = (cur < n) ? q[cur].wr : 1'b0;
      put(d, xt, xa, xw, (dp >= 0) ? {r[23:0], q[dp].d} : r, ri);
      if (ri) begin
        if (dp >= 0 && q[dp].wr && inwin(q[dp].a)) ref_mem[d][q[dp].a[7:0]] = q[dp].d;
        dp = (cur < n && q[cur].tr[1]) ? cur : -1;
        if (cur < n) cur++;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
    q.delete();
  endtask

  task automatic random_xfers(input int count);
    int          r;
    logic [1:0]  tr;
    logic [31:0] a;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(99);
      tr = (r < 10) ? HTRANS_IDLE : (r < 15) ? HTRANS_BUSY : (r < 55) ? HTRANS_NONSEQ : HTRANS_SEQ;
      if ($urandom_range(99) < 85) begin
        a = BASE | 32'(($urandom_range(1) == 1) ? $urandom_range(15) : $urandom_range(255));
      end else begin
        a = $urandom();
        if (inwin(a)) a[31] = ~a[31];
      end
      push(tr, a, 1'($urandom_range(1)), 8'($urandom_range(255)));
    end
  endtask

  logic        rdy;
  logic [1:0]  resp;
  logic [31:0] rd;

  initial begin
    Hreset = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    put(0, HTRANS_IDLE, '0, 1'b0, '0, 1'b1);
    put(1, HTRANS_IDLE, '0, 1'b0, '0, 1'b1);
    repeat (3) @(negedge Hclk);
    for (int d = 0; d < 2; d++) begin
      get(d, rdy, resp, rd);
      chk($sformatf("d%0d reset hreadyout", d), {31'h0, rdy}, 32'd1);
      chk($sformatf("d%0d reset hresp", d), {30'h0, resp}, 32'd0);
      chk($sformatf("d%0d reset hrdata", d), rd, 32'd0);
    end
    Hreset = 1'b0;

    // Known contents everywhere
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 256; a++) push(HTRANS_NONSEQ, BASE | 32'(a), 1'b1, 8'($urandom_range(255)));
      run(d, 0);
    end

    // Single write then read
    push(HTRANS_NONSEQ, 32'h8000_0001, 1'b1, 8'hA3);
    push(HTRANS_IDLE,   32'h0,         1'b0, 8'h00);
    push(HTRANS_NONSEQ, 32'h8000_0001, 1'b0, 8'h00);
    push(HTRANS_IDLE,   32'h0,         1'b0, 8'h00);
    run(0, 0);

    // Incrementing burst write then read back
    push(HTRANS_NONSEQ, 32'h8000_0001, 1'b1, 8'h11);
    push(HTRANS_SEQ,    32'h8000_0002, 1'b1, 8'h22);
    push(HTRANS_SEQ,    32'h8000_0003, 1'b1, 8'h33);
    push(HTRANS_SEQ,    32'h8000_0004, 1'b1, 8'h44);
    push(HTRANS_NONSEQ, 32'h8000_0001, 1'b0, 8'h00);
    push(HTRANS_SEQ,    32'h8000_0002, 1'b0, 8'h00);
    push(HTRANS_SEQ,    32'h8000_0003, 1'b0, 8'h00);
    push(HTRANS_SEQ,    32'h8000_0004, 1'b0, 8'h00);
    run(0, 0);

    // Out of window and window edges
    push(HTRANS_NONSEQ, 32'h9000_0000, 1'b1, 8'hEE);
    push(HTRANS_NONSEQ, 32'h8000_0000, 1'b0, 8'h00);
    push(HTRANS_NONSEQ, 32'h7FFF_FFFF, 1'b1, 8'hEE);
    push(HTRANS_NONSEQ, 32'h8000_0100, 1'b0, 8'h00);
    push(HTRANS_NONSEQ, 32'h8000_00FF, 1'b1, 8'h96);
    push(HTRANS_NONSEQ, 32'h8000_00FF, 1'b0, 8'h00);
    push(HTRANS_NONSEQ, 32'h8000_0000, 1'b0, 8'h00);
    run(0, 0);

    // Write then immediate read of the same byte
    push(HTRANS_NONSEQ, 32'h8000_0010, 1'b1, 8'h5A);
    push(HTRANS_NONSEQ, 32'h8000_0010, 1'b0, 8'h00);
    run(0, 0);

    // Wait states: read with a held follow-on, then with foreign stalls
    push(HTRANS_NONSEQ, 32'h8000_00A2, 1'b0, 8'h00);
    push(HTRANS_NONSEQ, 32'h8000_00A3, 1'b0, 8'h00);
    push(HTRANS_NONSEQ, 32'h9000_00A2, 1'b1, 8'h01);
    push(HTRANS_IDLE,   32'h0,         1'b0, 8'h00);
    push(HTRANS_NONSEQ, 32'h8000_00A2, 1'b1, 8'h3C);
    push(HTRANS_NONSEQ, 32'h8000_00A2, 1'b0, 8'h00);
    push(HTRANS_NONSEQ, 32'h8000_0020, 1'b1, 8'hC4);
    run(1, 30);

    // Reset during the wait of a write to 8000_0020
    @(negedge Hclk);
    put(1, HTRANS_NONSEQ, 32'h8000_0020, 1'b1, 32'h0, 1'b1);
    @(negedge Hclk);
    get(1, rdy, resp, rd);
    chk("d1 wait before reset", {31'h0, rdy}, 32'd0);
    put(1, HTRANS_IDLE, 32'h0, 1'b0, 32'h0000_0077, 1'b0);
    Hreset = 1'b1;
    @(negedge Hclk);
    Hreset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    get(1, rdy, resp, rd);
    chk("d1 post-reset hreadyout", {31'h0, rdy}, 32'd1);
    chk("d1 post-reset hresp", {30'h0, resp}, 32'd0);
    chk("d1 post-reset hrdata", rd, 32'd0);
    put(1, HTRANS_IDLE, 32'h0, 1'b0, 32'h0, 1'b1);
    push(HTRANS_NONSEQ, 32'h8000_0020, 1'b0, 8'h00);
    run(1, 0);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      random_xfers(300);
      run(d, 20);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
